// File: rtl/reg_bus_master.sv
// Single-outstanding register bus initiator: one host command in, one bus transaction, one response out.
// Optional ack timeout enabled by defining REG_MST_TIMEOUT_EN.
module reg_bus_master #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic            mclk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            reg_cs,
  output logic            reg_wr,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e state_q;
  logic   timeout;

  assign cmd_ready = (state_q == StIdle);

`ifdef REG_MST_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] to_cnt_q;

  // The edge that would make the count reach TO_CYCLES is the timeout edge.
  assign timeout = (state_q == StReq) && (to_cnt_q == CW'(TO_CYCLES - 1));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (state_q == StIdle && cmd_valid) begin
      to_cnt_q <= '0;
    end else if (state_q == StReq) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end
`else
  assign timeout = (TO_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            reg_cs    <= 1'b1;
            reg_wr    <= cmd_wr;
            reg_addr  <= cmd_addr;
            reg_wdata <= cmd_wdata;
            reg_be    <= cmd_be;
            state_q   <= StReq;
          end
        end
        StReq: begin
          // Ack wins over a coincident timeout; cs drops on this edge so only one ack is seen.
          if (reg_ack || timeout) begin
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
            rsp_rdata <= (reg_ack && !reg_wr) ? reg_rdata : '0;
            rsp_err   <= !reg_ack;
            rsp_valid <= 1'b1;
            state_q   <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed spec vectors plus randomized transactions
// checked against a transaction-level reference model. Honours REG_MST_TIMEOUT_EN.
module tb_reg_bus_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int TO = 16;
`ifdef REG_MST_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [BW-1:0] cmd_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          reg_cs, reg_wr, reg_ack;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [BW-1:0] reg_be;

  reg_bus_master #(
    .AW       (AW),
    .DW       (DW),
    .TO_CYCLES(TO)
  ) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_be   (cmd_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .reg_cs   (reg_cs),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_be   (reg_be),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Responder: acks ack_delay cycles after it first sees cs, or never; can inject one stray ack.
  int          ack_delay = 1;
  bit          ack_never = 1'b0;
  bit          stray_req = 1'b0;
  logic [31:0] rd_value  = '0;
  int          cs_cnt    = 0;

  initial begin
    reg_ack   = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge mclk);
      #2;
      reg_ack   = 1'b0;
      reg_rdata = $urandom;
      if (stray_req) begin
        reg_ack   = 1'b1;
        stray_req = 1'b0;
      end else if (reg_cs) begin
        cs_cnt++;
        if (!ack_never && cs_cnt == ack_delay + 1) begin
          reg_ack   = 1'b1;
          reg_rdata = rd_value;
        end
      end else begin
        cs_cnt = 0;
      end
    end
  end

  task automatic check_idle_bus(input string tag);
    check_eq({tag, "_cs"}, reg_cs, 1'b0);
    check_eq({tag, "_wr"}, reg_wr, 1'b0);
    check_eq({tag, "_addr"}, reg_addr, '0);
    check_eq({tag, "_wdata"}, reg_wdata, '0);
    check_eq({tag, "_be"}, reg_be, '0);
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [BW-1:0] be, input logic [DW-1:0] rdv, input int delay,
                         input bit never, input int hold, input bit stray);
    int            rsp_k;
    int            exp_cs;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] got_rdata;
    ack_delay = delay;
    ack_never = never;
    rd_value  = rdv;
    // Reference model: ack lands delay+1 edges after accept unless the timeout edge comes first.
    if (!never && (!TimeoutEn || delay + 1 <= TO)) begin
      exp_cs    = delay + 1;
      exp_err   = 1'b0;
      exp_rdata = wr ? '0 : rdv;
    end else begin
      exp_cs    = TO;
      exp_err   = 1'b1;
      exp_rdata = '0;
    end
    @(posedge mclk);
    #1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    @(negedge mclk);
    check_eq("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge mclk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr    = $urandom;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_be    = $urandom;
    rsp_k     = -1;
    for (int k = 0; k < 64 && rsp_k < 0; k++) begin
      @(negedge mclk);
      if (rsp_valid) begin
        rsp_k = k;
      end else begin
        check_eq("req_cs", reg_cs, 1'b1);
        check_eq("req_wr", reg_wr, wr);
        check_eq("req_addr", reg_addr, addr);
        check_eq("req_wdata", reg_wdata, wdata);
        check_eq("req_be", reg_be, be);
        check_eq("req_cmd_ready", cmd_ready, 1'b0);
      end
    end
    if (rsp_k < 0) begin
      check_eq("rsp_valid_never_seen", 1'b0, 1'b1);
      return;
    end
    check_eq("rsp_latency", rsp_k, exp_cs);
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("rsp_cmd_ready", cmd_ready, 1'b0);
    check_idle_bus("rsp_bus");
    got_rdata = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      if (stray && h == 1) stray_req = 1'b1;
      @(negedge mclk);
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_rdata", rsp_rdata, exp_rdata);
      check_eq("hold_err", rsp_err, exp_err);
      check_eq("hold_cmd_ready", cmd_ready, 1'b0);
      check_eq("hold_cs", reg_cs, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge mclk);
    #1;
    rsp_ready = 1'b0;
    @(negedge mclk);
    check_eq("post_valid", rsp_valid, 1'b0);
    check_eq("post_cmd_ready", cmd_ready, 1'b1);
    check_eq("post_rdata_kept", rsp_rdata, got_rdata);
    check_idle_bus("post_bus");
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, '0);
    check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
    check_idle_bus(tag);
  endtask

  initial begin
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_be    = '0;
    rsp_ready = 1'b0;
    #3 reset_n = 1'b0;
    #10;
    check_reset_state("reset");
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    check_reset_state("after_release");

    run_txn(1'b1, 8'h00, 32'h12345678, 4'hF, 32'h0, 1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 8'h24, 32'h0, 4'hF, 32'h4C668354, 1, 1'b0, 0, 1'b0);
    run_txn(1'b1, 8'h08, 32'h0000FF00, 4'b0010, 32'h0, 3, 1'b0, 0, 1'b0);
    run_txn(1'b0, 8'h10, 32'h0, 4'hF, 32'hA5A5_0F0F, 1, 1'b0, 5, 1'b1);
    if (TimeoutEn) begin
      run_txn(1'b0, 8'h30, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 1'b1, 4, 1'b1);
      run_txn(1'b0, 8'h34, 32'h0, 4'hF, 32'h1357_9BDF, TO - 1, 1'b0, 0, 1'b0);
      run_txn(1'b0, 8'h38, 32'h0, 4'hF, 32'h2468_ACE0, TO, 1'b0, 2, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      int hold;
      hold = $urandom_range(0, 5);
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom), DW'($urandom),
              TimeoutEn ? $urandom_range(1, 18) : $urandom_range(1, 6), 1'b0, hold,
              (hold >= 3) ? 1'($urandom) : 1'b0);
    end

    // Reset while a command is outstanding in REQ.
    ack_never = 1'b1;
    @(posedge mclk);
    #1;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 8'h44;
    cmd_wdata = 32'hCAFE_F00D;
    cmd_be    = 4'hF;
    @(posedge mclk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check_eq("pre_reset_cs", reg_cs, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(posedge mclk);
    #1 reset_n = 1'b1;
    ack_never = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      check_reset_state("post_reset");
    end

    // Stray ack while idle must not start anything.
    stray_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      check_reset_state("stray_idle");
    end

    run_txn(1'b0, 8'h48, 32'h0, 4'h3, 32'h0BAD_C0DE, 2, 1'b0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
